// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin arbiter sharing one 8-bit framing serializer among N requesters,
// with a watchdog that resets the serializer when a frame never completes.
module serializer_arbiter #(
  parameter int N = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout_err,
  output logic [7:0]     ser_data,
  output logic           ser_load,
  output logic           ser_reset,
  input  logic           ser_ready
);
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, RECOVER} state_t;
  state_t state, state_n;
  logic [LW-1:0] last, win;
  logic [N-1:0] win_oh;
  logic [2*N-1:0] rot;
  logic [CW-1:0] cnt;
  logic expired;
  int off;
  // rotate requests so bit 0 is the requester just after the last winner
  always_comb begin
    rot = {req, req} >> (int'(last) + 1);
    off = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    win = LW'((int'(last) + 1 + off) % N);
  end
  assign win_oh = N'(1) << win;
  assign expired = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = ser_ready && |req ? LOAD : IDLE;
      LOAD:       state_n = WAIT_START;
      WAIT_START: state_n = expired ? RECOVER : !ser_ready ? WAIT_DONE : WAIT_START;
      WAIT_DONE:  state_n = ser_ready ? IDLE : expired ? RECOVER : WAIT_DONE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last        <= LW'(N - 1);
      grant       <= '0;
      ack         <= '0;
      ser_load    <= 1'b0;
      ser_data    <= 8'h00;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_n;
      ack      <= '0;
      ser_load <= 1'b0;
      cnt      <= (state == WAIT_START || state == WAIT_DONE) ? cnt + 1'b1 : '0;
      if (state == IDLE && state_n == LOAD) begin
        grant    <= win_oh;
        ack      <= win_oh;
        ser_load <= 1'b1;
        ser_data <= req_data[8*win +: 8];
        last     <= win;
      end
      if (state_n == RECOVER) timeout_err <= 1'b1;
      if (state_n == RECOVER || (state == WAIT_DONE && state_n == IDLE)) grant <= '0;
    end
  end
  assign busy = state != IDLE;
  assign ser_reset = reset | (state == RECOVER);
endmodule

// File: tb/tb_serializer_arbiter.sv
// tb_serializer_arbiter: scoreboard bench with a framing serializer model, per-requester byte queues
// and a round-robin reference model that predicts the grant order and frame contents.
module tb_serializer_arbiter;
  localparam int N = 4;
  localparam int TIMEOUT = 32;
  localparam int NORM = 0, SBUSY = 1, SREADY = 2;
  typedef struct {
    int idx;
    logic [7:0] data;
  } ent_t;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] ack, grant;
  logic busy, timeout_err, ser_load, ser_reset, ser_ready;
  logic [7:0] ser_data;
  int checks = 0, errors = 0, cyc = 0;
  int nb[N], hd[N];
  logic [7:0] bt[N][8];
  ent_t exp_ack[$];
  logic [7:0] exp_frame[$];
  int mlast = N - 1, exp_rec = 0, rec_cnt = 0, cur_idx = 0, load_cyc = 0;
  logic exp_terr = 1'b0, prev_sr = 1'b0;
  int stuck_at = -1, stuck_mode = NORM, n_loads = 0, m_mode = NORM, m_cnt = 0;
  logic m_ready = 1'b1;
  logic [9:0] m_sh = '1, dec = '0;
  logic tx;

  serializer_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .grant(grant),
    .busy(busy), .timeout_err(timeout_err), .ser_data(ser_data), .ser_load(ser_load),
    .ser_reset(ser_reset), .ser_ready(ser_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // serializer: 10-bit frame (start, 8 data LSB first, stop), 2 cycles per bit, ready low for 20 cycles
  assign ser_ready = m_ready;
  assign tx = (!m_ready && m_mode == NORM) ? m_sh[m_cnt/2] : 1'b1;
  always @(posedge clock) begin
    if (ser_reset) begin
      m_ready <= 1'b1;
      m_cnt <= 0;
    end else if (m_ready) begin
      if (ser_load) begin
        n_loads <= n_loads + 1;
        if ((n_loads == stuck_at ? stuck_mode : NORM) != SREADY) begin
          m_ready <= 1'b0;
          m_cnt <= 0;
          m_sh <= {1'b1, ser_data, 1'b0};
          m_mode <= n_loads == stuck_at ? stuck_mode : NORM;
        end
      end
    end else if (m_mode != SBUSY) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 19) m_ready <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  always @(negedge clock) begin : monitor
    ent_t e;
    if (!reset) begin
      if (ack != '0 || ser_load) begin
        if (exp_ack.size() == 0) chk("unexpected_ack", 32'(ack), 32'(0));
        else begin
          e = exp_ack.pop_front();
          chk("ack", 32'(ack), 32'(1) << e.idx);
          chk("ack_grant", 32'(grant), 32'(1) << e.idx);
          chk("ser_load", 32'(ser_load), 32'(1));
          chk("ser_data", 32'(ser_data), 32'(e.data));
          cur_idx = e.idx;
          load_cyc = cyc;
        end
      end
      if (!m_ready && m_mode == NORM) begin
        chk("grant_in_flight", 32'(grant), 32'(1) << cur_idx);
        chk("busy_in_flight", 32'(busy), 32'(1));
      end
      if (!busy) chk("idle_grant", 32'(grant), 32'(0));
      if (ser_reset) begin
        rec_cnt++;
        chk("recover_delay", 32'(cyc - load_cyc), 32'(TIMEOUT + 1));
        chk("recover_width", 32'(prev_sr), 32'(0));
        chk("timeout_err_set", 32'(timeout_err), 32'(1));
      end
      prev_sr = ser_reset;
      if (!m_ready && m_mode == NORM && m_cnt % 2 == 1) begin
        dec = {tx, dec[9:1]};
        if (m_cnt == 19) begin
          if (exp_frame.size() == 0) chk("unexpected_frame", 32'(dec), 32'(0));
          else begin
            chk("frame_start_stop", 32'({dec[9], dec[0]}), 32'(2));
            chk("frame_data", 32'(dec[8:1]), 32'(exp_frame.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = hd[i] < nb[i];
      if (hd[i] < nb[i]) req_data[8*i +: 8] = bt[i][hd[i]];
    end
  endtask

  // each requester holds its front byte until ack, then presents the next one
  initial forever begin
    @(negedge clock);
    if (!reset) for (int i = 0; i < N; i++) if (ack[i]) hd[i]++;
    drive();
  end

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      nb[i] = 0;
      hd[i] = 0;
    end
  endtask

  task automatic add(input int i, input logic [7:0] b);
    bt[i][nb[i]] = b;
    nb[i]++;
  endtask

  // all requests are pending together, so grants follow plain round-robin over the remaining bytes
  task automatic launch(input int smode);
    int rem[N];
    int found;
    int first;
    ent_t e;
    first = 1;
    for (int i = 0; i < N; i++) rem[i] = nb[i] - hd[i];
    stuck_mode = smode;
    stuck_at = smode == NORM ? -1 : n_loads;
    while (1) begin
      found = -1;
      for (int k = 1; k <= N; k++) if (found < 0 && rem[(mlast + k) % N] > 0) found = (mlast + k) % N;
      if (found < 0) break;
      e.idx = found;
      e.data = bt[found][nb[found] - rem[found]];
      exp_ack.push_back(e);
      if (!(first == 1 && smode != NORM)) exp_frame.push_back(e.data);
      first = 0;
      rem[found]--;
      mlast = found;
    end
    if (smode != NORM) begin
      exp_rec++;
      exp_terr = 1'b1;
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (!(exp_ack.size() == 0 && exp_frame.size() == 0 && !busy && m_ready) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: %0d acks and %0d frames still expected after %0d cycles", tag, exp_ack.size(), exp_frame.size(), t);
    end
    repeat (3) @(negedge clock);
    chk({"timeout_err_", tag}, 32'(timeout_err), 32'(exp_terr));
    chk({"recover_count_", tag}, 32'(rec_cnt), 32'(exp_rec));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mlast = N - 1;
    exp_terr = 1'b0;
    exp_ack.delete();
    exp_frame.delete();
    clear();
    drive();
  endtask

  initial begin
    int t, total;
    clear();
    drive();
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ser_load", 32'(ser_load), 32'(0));
    chk("rst_ser_data", 32'(ser_data), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    chk("rst_ser_reset", 32'(ser_reset), 32'(1));
    reset = 1'b0;
    @(negedge clock);
    chk("ser_reset_released", 32'(ser_reset), 32'(0));

    add(2, 8'hA5);
    launch(NORM);
    @(negedge clock);
    chk("single_ack", 32'(ack), 32'(4));
    chk("single_load", 32'(ser_load), 32'(1));
    chk("single_data", 32'(ser_data), 32'(8'hA5));
    chk("single_grant", 32'(grant), 32'(4));
    drain("single");

    do_reset();
    add(0, 8'($urandom));
    add(0, 8'($urandom));
    for (int i = 1; i < N; i++) add(i, 8'($urandom));
    launch(NORM);
    drain("fair");

    clear();
    add(1, 8'($urandom));
    launch(NORM);
    drain("skip_setup");
    clear();
    add(1, 8'($urandom));
    add(3, 8'($urandom));
    launch(NORM);
    drain("skip");

    clear();
    add(0, 8'($urandom));
    add(2, 8'($urandom));
    launch(SBUSY);
    drain("stuck_busy");

    clear();
    add(1, 8'($urandom));
    add(3, 8'($urandom));
    launch(SREADY);
    drain("stuck_ready");

    repeat (6) begin
      clear();
      total = 0;
      for (int i = 0; i < N; i++) begin
        t = $urandom_range(0, 3);
        total += t;
        repeat (t) add(i, 8'($urandom));
      end
      if (total == 0) add($urandom_range(0, N - 1), 8'($urandom));
      launch(NORM);
      drain("random");
    end

    clear();
    add(2, 8'h3C);
    launch(NORM);
    t = 0;
    while (!(!m_ready && m_cnt == 5) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL midreset_wait: frame never reached WAIT_DONE within %0d cycles", t);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("mid_grant", 32'(grant), 32'(0));
    chk("mid_busy", 32'(busy), 32'(0));
    chk("mid_ser_load", 32'(ser_load), 32'(0));
    chk("mid_ser_reset", 32'(ser_reset), 32'(1));
    chk("mid_timeout_err", 32'(timeout_err), 32'(0));
    exp_frame.delete();
    mlast = N - 1;
    exp_terr = 1'b0;
    reset = 1'b0;
    clear();
    for (int i = 0; i < N; i++) add(i, 8'($urandom));
    launch(NORM);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin arbiter that shares one 8-bit framing serializer between N byte-producing requesters. It picks a requester, presents its byte on the serializer's data/load inputs, and waits for the serializer's ready output to go low and then high again. After that it grants the next requester. A watchdog resets the serializer if a frame never completes.

## Interface
- N, default 4: number of requesters, at least 2.
- TIMEOUT, default 32: maximum cycles from the load pulse to frame completion. Must exceed the serializer frame length of 20 cycles.
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level.
- req_data  in  8N  requester i's byte is bits [8i+7:8i].
- ack  out  N  one-hot, one-cycle pulse: the requester's byte has been handed to the serializer.
- grant  out  N  one-hot owner of the current frame; all zeros when idle.
- busy  out  1  high whenever the FSM is not in IDLE.
- timeout_err  out  1  sticky watchdog flag; cleared only by reset.
- ser_data  out  8  byte driven to the serializer data input.
- ser_load  out  1  one-cycle load strobe to the serializer.
- ser_reset  out  1  reset to the serializer, equal to (reset OR recover pulse).
- ser_ready  in  1  serializer ready; high means idle.

## Operation
- FSM states are IDLE, LOAD, WAIT_START, WAIT_DONE and RECOVER.
- **IDLE**: if ser_ready=1 and req≠0, choose a winner and go to LOAD.
  - Winner search starts at last+1 (mod N) and takes the first set req bit.
  - Register grant, ser_data <= winner's byte, ser_load <= 1, ack <= onehot(winner), last <= winner.
  - If ser_ready=0 in IDLE, no grant is issued.
- **LOAD**: ser_load=1 and ack is high for exactly this cycle. Clear both next cycle, go to WAIT_START, clear the watchdog counter.
- **WAIT_START**: wait for ser_ready=0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for ser_ready=1, then clear grant and go to IDLE.
- **Watchdog**: counter increments every cycle in WAIT_START and WAIT_DONE.
  - When it reaches TIMEOUT-1 without completion, go to RECOVER.
- **RECOVER**: ser_reset=1 for exactly one cycle, timeout_err <= 1, grant cleared, then IDLE. last is not rewound, so the failed requester loses its turn.
- **Data capture**: the byte is captured in the arbitration cycle. A requester dropping req or changing data afterwards does not alter the frame in flight.
- **Requester contract**: hold req and data stable until ack.
  - After ack, a requester with req still high is treated as having a new byte pending. It competes again in the next IDLE.
- **Reset**: at any time, including mid-frame, reset returns the FSM to IDLE on the next edge.
  - Cleared: grant, ack, ser_load, ser_data (0x00), busy, timeout_err and the watchdog counter.
  - last is set to N-1, so requester 0 has first priority.
  - ser_reset is high while reset is high.

## Timing
- Arbitration cycle t (IDLE, ser_ready=1, req≠0) gives ser_load=1 and ack=1 in cycle t+1.
- The serializer latches at the end of t+1, and ser_ready drops in t+2.
- grant is valid from t+1 until the cycle after ser_ready returns high. busy follows the same window.
- Minimum gap between consecutive ser_load pulses is frame length + 2 cycles: WAIT_DONE→IDLE takes one edge, and arbitration takes one cycle.
- No combinational path from req or ser_ready to any output except ser_reset's OR with reset.

## Test plan
- **Single request**
  - Stimulus: reset released; req=0100, req_data[23:16]=0xA5.
  - Required: ack=0100 and ser_load=1 one cycle after arbitration, ser_data=0xA5, grant=0100 until ser_ready rises.
  - Required: serializer model output decodes to 0xA5.
- **Fairness after reset**: req=1111 held continuously → grants in order 0,1,2,3,0, each after the previous frame completes; timeout_err stays 0.
- **Pointer skip**: last grant=1, req=1010 → next grant 3, then 1.
- **Stuck busy**: ser_ready forced 0 after load → ser_reset one-cycle pulse at load+TIMEOUT+1, timeout_err=1 sticky, FSM in IDLE, next requester granted when ser_ready=1.
- **Stuck ready**: ser_ready held 1 → same RECOVER behaviour via WAIT_START.
- **Mid-frame reset**: reset asserted during WAIT_DONE → next cycle grant=0, busy=0, ser_load=0, ser_reset=1; with req=1111 after release, requester 0 is granted first.
